present_enc_core: RTL and testbench
===================================

PRESENT_ENC_CORE -- requirements
Module: present_enc_core

Interface
REQ-001 No parameters; block width and round count are fixed by PRESENT-80 (64-bit block, 80-bit key, 31 rounds).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  plaintext/key offered.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 plaintext  input  64  block to encrypt; bit 63 is MSB.
REQ-007 key  input  80  cipher key; bit 79 is MSB.
REQ-008 out_valid  output  1  ciphertext valid.
REQ-009 out_ready  input  1  downstream consumes ciphertext.
REQ-010 ciphertext  output  64  encrypted block; meaningful only while out_valid=1.

Function
REQ-011 FSM states: IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE on the edge where round counter=31; DONE->IDLE on out_ready&&out_valid.
REQ-012 in_ready=1 only in IDLE; out_valid=1 only in DONE; both are decoded from state registers, not combinationally from inputs.
REQ-013 Accept edge: state_reg<=plaintext, key_reg<=key, round counter (5-bit)<=1; inputs are not sampled on any other edge.
REQ-014 Each RUN edge: state_reg<=P(S16(state_reg ^ key_reg[79:16])); S16 = 16 parallel 4-bit PRESENT S-boxes on nibbles [3:0]..[63:60].
REQ-015 S-box table (in->out, hex): 0-C 1-5 2-6 3-B 4-9 5-0 6-A 7-D 8-3 9-E A-F B-8 C-4 D-7 E-1 F-2.
REQ-016 P moves bit i to position (16*i) mod 63 for i=0..62; bit 63 stays at 63.
REQ-017 Same RUN edge key update: rotate key_reg left by 61, apply S-box to bits [79:76] of the rotated value, XOR round counter into bits [19:15].
REQ-018 Round counter increments by 1 per RUN edge, values 1..31; it does not wrap inside RUN.
REQ-019 ciphertext = state_reg ^ key_reg[79:16] (final whitening with K32), combinational from registers.
REQ-020 Latency: out_valid rises exactly 31 clock edges after the accept edge; minimum block interval is 33 cycles when out_ready=1.
REQ-021 In RUN/DONE, in_valid is ignored and plaintext/key changes have no effect.
REQ-022 With out_ready=0 the core holds DONE indefinitely; ciphertext stays bit-stable.
REQ-023 out_ready is don't-care outside DONE.

Reset
REQ-024 rst=1 forces IDLE, state_reg=0, key_reg=0, counter=0 immediately, without waiting for clk.
REQ-025 Reset values: in_ready=1, out_valid=0, ciphertext=64'h0.
REQ-026 Reset during RUN or DONE aborts the block; no out_valid is produced for it; the next block after rst deasserts is processed normally.

Verification
REQ-027 pt=0, key=0 -> ciphertext 5579C1387B228445, out_valid 31 edges after accept.
REQ-028 pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049; pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B.
REQ-029 pt and key all ones, out_ready held 0 for 50 cycles -> 3333DCD3213210D2 stable and out_valid=1 throughout; one out_ready pulse -> IDLE next edge.
REQ-030 in_valid held 1 with changing plaintext/key during RUN -> result equals vector of the accepted block; in_ready=0 throughout RUN/DONE.
REQ-031 rst asserted mid-RUN (round 10), then pt=0/key=0 accepted -> outputs zero immediately on rst, then 5579C1387B228445 with no spurious out_valid.
REQ-032 Back-to-back blocks with out_ready=1 and in_valid=1 -> accepts every 33 cycles, each ciphertext matches its vector.

Source files
------------

// File: rtl/present_enc_core.sv
// PRESENT-80 block cipher, iterative: one round per clock, 31 rounds, then
// final key whitening. A valid/ready handshake sits on each side.
module present_enc_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ciphertext
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  round_q, round_d;

  logic [63:0] round_out;
  logic [79:0] key_rot;
  logic [79:0] key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sub_nibbles(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Bit i lands at (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    return y;
  endfunction

  assign round_out = p_layer(sub_nibbles(state_q ^ key_q[79:16]));
  assign key_rot   = {key_q[18:0], key_q[79:19]};
  assign key_next  = {sbox(key_rot[79:76]), key_rot[75:20],
                      key_rot[19:15] ^ round_q, key_rot[14:0]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case leaves one unassigned and infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          fsm_d   = RUN;
          state_d = plaintext;
          key_d   = key;
          round_d = 5'd1;
        end
      end
      RUN: begin
        state_d = round_out;
        key_d   = key_next;
        // The counter parks at 31 rather than wrapping to 0.
        if (round_q == 5'd31) fsm_d = DONE;
        else                  round_d = round_q + 5'd1;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= 64'h0;
      key_q   <= 80'h0;
      round_q <= 5'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign ciphertext = state_q ^ key_q[79:16];

endmodule

// File: tb/tb_present_enc_core.sv
// Directed bench for present_enc_core: published PRESENT-80 vectors, latency,
// output hold, input isolation while busy, reset abort and back-to-back blocks.
module tb_present_enc_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ciphertext;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int accept_cyc;

  present_enc_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Offers one block, waits for acceptance, then for out_valid. Returns at
  // #1 after the edge on which DONE was entered. With scramble set, in_valid
  // stays high and plaintext/key change every cycle while the core is busy.
  task automatic do_block(input logic [63:0] pt, input logic [79:0] k,
                          input logic [63:0] exp, input string tag,
                          input bit scramble);
    int guard;
    int lat;
    bit busy_bad;
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    guard     = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " ready_before_accept"}, 80'(in_ready), 80'd1);
    @(posedge clk); #1;
    accept_cyc = cyc;
    if (!scramble) in_valid = 1'b0;
    lat      = 0;
    busy_bad = 1'b0;
    do begin
      if (scramble) begin
        plaintext = {$urandom, $urandom};
        key       = {16'($urandom), $urandom, $urandom};
      end
      busy_bad |= in_ready;
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    busy_bad |= in_ready;
    check({tag, " latency"}, 80'(lat), 80'd31);
    check({tag, " ciphertext"}, 80'(ciphertext), 80'(exp));
    check({tag, " in_ready_low_while_busy"}, 80'(busy_bad), 80'd0);
  endtask

  initial begin
    bit hold_bad;
    int prev_accept;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    plaintext = 64'h0;
    key       = 80'h0;

    #12;
    check("reset in_ready",   80'(in_ready),   80'd1);
    check("reset out_valid",  80'(out_valid),  80'd0);
    check("reset ciphertext", 80'(ciphertext), 80'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference vectors, downstream always ready.
    do_block(64'h0, 80'h0, 64'h5579C1387B228445, "v0", 1'b0);
    do_block(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "v1", 1'b0);
    do_block({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "v2", 1'b0);
    @(posedge clk); #1;
    check("return to idle", 80'(in_ready), 80'd1);

    // Downstream stall: DONE and ciphertext must hold until out_ready.
    out_ready = 1'b0;
    do_block({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, "v3", 1'b0);
    hold_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!out_valid || ciphertext !== 64'h3333DCD3213210D2 || in_ready) hold_bad = 1'b1;
    end
    check("stall hold", 80'(hold_bad), 80'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release out_valid", 80'(out_valid), 80'd0);
    check("release in_ready",  80'(in_ready),  80'd1);
    out_ready = 1'b1;

    // Abort mid-RUN with an asynchronous reset.
    in_valid  = 1'b1;
    plaintext = {64{1'b1}};
    key       = {80{1'b1}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst ciphertext", 80'(ciphertext), 80'h0);
    check("async rst out_valid",  80'(out_valid),  80'd0);
    check("async rst in_ready",   80'(in_ready),   80'd1);
    hold_bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid || ciphertext !== 64'h0) hold_bad = 1'b1;
    end
    check("held rst quiet", 80'(hold_bad), 80'd0);
    @(negedge clk);
    rst = 1'b0;
    do_block(64'h0, 80'h0, 64'h5579C1387B228445, "after_rst", 1'b0);

    // Back-to-back with in_valid held and busy-time input churn.
    @(posedge clk); #1;
    do_block(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "b2b0", 1'b1);
    prev_accept = accept_cyc;
    do_block({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "b2b1", 1'b1);
    check("b2b interval 1", 80'(accept_cyc - prev_accept), 80'd33);
    prev_accept = accept_cyc;
    do_block(64'h0, 80'h0, 64'h5579C1387B228445, "b2b2", 1'b1);
    check("b2b interval 2", 80'(accept_cyc - prev_accept), 80'd33);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("final idle", 80'(in_ready), 80'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
